// File: rtl/rsa_ip_ctrl_pkg.sv
// Shared types and sizing helpers for the RSA_IP sequencer and its modular
// exponentiation step.
package rsa_ip_ctrl_pkg;

   localparam int RSA_WIDTH   = 3;
   localparam int RSA_SETTLE  = 1;
   localparam int RSA_MSG_NUM = 8;

   localparam int RSA_NW = 2 * RSA_WIDTH;
   localparam int RSA_PW = 4 * RSA_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_EXP,
      ST_OUT
   } rsa_state_t;

   // A counter that only ever holds 0 still needs one bit of storage.
   function automatic int cnt_width(input int range);
      return (range <= 2) ? 1 : $clog2(range);
   endfunction

   localparam int RSA_MSG_CW    = cnt_width(RSA_MSG_NUM);
   localparam int RSA_BIT_CW    = cnt_width(RSA_NW);
   localparam int RSA_SETTLE_CW = cnt_width(RSA_SETTLE + 1);

endpackage

// File: rtl/rsa_ip_ctrl_modexp_step.sv
// One square-and-multiply step of M = C^D mod N: acc_next = acc^2 [* base] mod n,
// with a degenerate modulus (n <= 1) forcing the result to zero.
module rsa_modexp_step
   import rsa_ip_ctrl_pkg::*;
#(
   parameter int NW = RSA_NW
) (
   input  logic [NW-1:0] acc,
   input  logic [NW-1:0] base,
   input  logic          exp_bit,
   input  logic [NW-1:0] n,
   output logic [NW-1:0] acc_next
);

   localparam int PW = 2 * NW;

   logic          degenerate;
   logic [PW-1:0] n_ext;
   logic [PW-1:0] sq;
   logic [PW-1:0] sq_mod;
   logic [PW-1:0] mul;
   logic [PW-1:0] mul_mod;

   // The divisor is swapped for 1 on a degenerate modulus so no divide-by-zero
   // path exists; the result is then overridden to 0 anyway.
   always_comb begin
      degenerate = (n <= NW'(1));
      n_ext      = degenerate ? PW'(1) : PW'(n);
      sq         = PW'(acc) * PW'(acc);
      sq_mod     = sq % n_ext;
      mul        = exp_bit ? (sq_mod * PW'(base)) : sq_mod;
      mul_mod    = mul % n_ext;
      acc_next   = degenerate ? '0 : NW'(mul_mod);
   end

endmodule

// File: rtl/rsa_ip_ctrl.sv
// Sequencer around the combinational RSA_IP key generator: gathers a key set and
// MSG_NUM ciphertexts, captures N/D, decrypts each message and streams plaintexts out.
module rsa_ip_ctrl
   import rsa_ip_ctrl_pkg::*;
#(
   parameter int WIDTH   = RSA_WIDTH,
   parameter int SETTLE  = RSA_SETTLE,
   parameter int MSG_NUM = RSA_MSG_NUM
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_p,
   input  logic [WIDTH-1:0]   in_q,
   input  logic [2*WIDTH-1:0] in_e,
   input  logic [2*WIDTH-1:0] in_c,
   output logic [WIDTH-1:0]   ip_p,
   output logic [WIDTH-1:0]   ip_q,
   output logic [2*WIDTH-1:0] ip_e,
   input  logic [2*WIDTH-1:0] ip_n,
   input  logic [2*WIDTH-1:0] ip_d,
   output logic               out_valid,
   output logic [2*WIDTH-1:0] out_m
);

   localparam int NW    = 2 * WIDTH;
   localparam int MSG_W = cnt_width(MSG_NUM);
   localparam int BIT_W = cnt_width(NW);
   localparam int SET_W = cnt_width(SETTLE + 1);

   rsa_state_t state;
   rsa_state_t state_next;

   logic [MSG_W-1:0] beat_cnt;
   logic [MSG_W-1:0] msg_cnt;
   logic [MSG_W-1:0] msg_inc;
   logic [BIT_W-1:0] bit_cnt;
   logic [SET_W-1:0] settle_cnt;

   logic [NW-1:0] msg_buf [MSG_NUM];
   logic [NW-1:0] n_r;
   logic [NW-1:0] d_r;
   logic [NW-1:0] acc;
   logic [NW-1:0] acc_src;
   logic [NW-1:0] acc_next;
   logic [NW-1:0] base;
   logic [NW-1:0] first_out;
   logic          exp_bit;

   logic beat_last;
   logic msg_last;
   logic bit_last;
   logic settle_last;

   always_comb begin
      beat_last   = (beat_cnt == MSG_W'(MSG_NUM - 1));
      msg_last    = (msg_cnt == MSG_W'(MSG_NUM - 1));
      bit_last    = (bit_cnt == BIT_W'(NW - 1));
      settle_last = (settle_cnt == SET_W'(SETTLE - 1));
      msg_inc     = msg_cnt + MSG_W'(1);
   end

   // Each message restarts from acc = 1 on its first bit, scanning d_r MSB-first.
   always_comb begin
      acc_src   = (bit_cnt == '0) ? NW'(1) : acc;
      base      = msg_buf[msg_cnt];
      exp_bit   = d_r[BIT_W'(NW - 1) - bit_cnt];
      first_out = (MSG_NUM == 1) ? acc_next : msg_buf[0];
   end

   rsa_modexp_step #(
      .NW (NW)
   ) u_step (
      .acc      (acc_src),
      .base     (base),
      .exp_bit  (exp_bit),
      .n        (n_r),
      .acc_next (acc_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               state_next = (MSG_NUM == 1) ? ST_SETTLE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (in_valid && beat_last) begin
               state_next = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_last) begin
               state_next = ST_EXP;
            end
         end
         ST_EXP: begin
            if (bit_last && msg_last) begin
               state_next = ST_OUT;
            end
         end
         ST_OUT: begin
            if (msg_last) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // The first plaintext is loaded into the output register on the same edge that
   // enters OUT, so out_valid lines up exactly with the OUT cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         ip_p       <= '0;
         ip_q       <= '0;
         ip_e       <= '0;
         out_valid  <= 1'b0;
         out_m      <= '0;
         beat_cnt   <= '0;
         msg_cnt    <= '0;
         bit_cnt    <= '0;
         settle_cnt <= '0;
         n_r        <= '0;
         d_r        <= '0;
         acc        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  ip_p       <= in_p;
                  ip_q       <= in_q;
                  ip_e       <= in_e;
                  msg_buf[0] <= in_c;
                  beat_cnt   <= MSG_W'(1);
                  settle_cnt <= '0;
               end
            end
            ST_LOAD: begin
               if (in_valid) begin
                  msg_buf[beat_cnt] <= in_c;
                  beat_cnt          <= beat_cnt + MSG_W'(1);
               end
            end
            ST_SETTLE: begin
               if (settle_last) begin
                  n_r        <= ip_n;
                  d_r        <= ip_d;
                  settle_cnt <= '0;
                  bit_cnt    <= '0;
                  msg_cnt    <= '0;
               end else begin
                  settle_cnt <= settle_cnt + SET_W'(1);
               end
            end
            ST_EXP: begin
               acc <= acc_next;
               if (bit_last) begin
                  bit_cnt          <= '0;
                  msg_buf[msg_cnt] <= acc_next;
                  if (msg_last) begin
                     msg_cnt   <= '0;
                     out_valid <= 1'b1;
                     out_m     <= first_out;
                  end else begin
                     msg_cnt <= msg_inc;
                  end
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
            ST_OUT: begin
               if (msg_last) begin
                  out_valid <= 1'b0;
                  out_m     <= '0;
                  msg_cnt   <= '0;
                  beat_cnt  <= '0;
               end else begin
                  out_m   <= msg_buf[msg_inc];
                  msg_cnt <= msg_inc;
               end
            end
            default: begin
               out_valid <= 1'b0;
               out_m     <= '0;
            end
         endcase
      end
   end

endmodule
